// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH storage bits that act together as D, T or JK flip-flops, or as a
// binary counter with a registered terminal-count pulse on wrap.
module multi_mode_ff_bank #(
    parameter int unsigned      WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_D     = 2'b00,
        MODE_T     = 2'b01,
        MODE_JK    = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    mode_e            mode_sel;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;

    assign mode_sel = mode_e'(mode);

    // NOTE: defaults first so every path assigns q_d/tc_d and no latch is inferred.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (en) begin
            unique case (mode_sel)
                MODE_D:  q_d = a;
                MODE_T:  q_d = q_q ^ a;
                // J sets the bits that are low, a clear K keeps the bits that are high.
                MODE_JK: q_d = (a & ~q_q) | (~b & q_q);
                MODE_COUNT: begin
                    q_d  = q_q + WIDTH'(1);
                    tc_d = &q_q;
                end
            endcase
        end
    end

    // NOTE: non-blocking assignments so all bits and tc see the same pre-edge state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q  <= RESET_VALUE;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Bench for multi_mode_ff_bank: three instances (4-bit reset 0, 4-bit reset 1010,
// 1-bit) share the stimulus; a per-bit arithmetic model is compared every cycle.
module tb_multi_mode_ff_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;

    logic [3:0] q0, qb0, q1, qb1;
    logic       q2, qb2;
    logic       tc0, tc1, tc2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_mode_ff_bank #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .q(q0), .q_bar(qb0), .tc(tc0)
    );
    multi_mode_ff_bank #(.WIDTH(4), .RESET_VALUE(4'b1010)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
        .q(q1), .q_bar(qb1), .tc(tc1)
    );
    multi_mode_ff_bank #(.WIDTH(1), .RESET_VALUE(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a[0]), .b(b[0]),
        .q(q2), .q_bar(qb2), .tc(tc2)
    );

    logic [31:0] dq[3];
    logic [31:0] dqb[3];
    logic [31:0] dtc[3];
    assign dq[0]  = {28'b0, q0};
    assign dq[1]  = {28'b0, q1};
    assign dq[2]  = {31'b0, q2};
    assign dqb[0] = {28'b0, qb0};
    assign dqb[1] = {28'b0, qb1};
    assign dqb[2] = {31'b0, qb2};
    assign dtc[0] = {31'b0, tc0};
    assign dtc[1] = {31'b0, tc1};
    assign dtc[2] = {31'b0, tc2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned widths[3] = '{4, 4, 1};
    logic [31:0] rvals[3]  = '{32'h0, 32'hA, 32'h0};
    logic [31:0] m_q[3]    = '{32'h0, 32'hA, 32'h0};
    logic        m_tc[3]   = '{1'b0, 1'b0, 1'b0};
    logic [31:0] m_nq[3];
    logic        m_ntc[3];

    function automatic logic [31:0] mask_of(input int unsigned w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    function automatic void model_step(input int unsigned w, input logic [31:0] cq,
                                       input logic [1:0] md, input logic [31:0] ai,
                                       input logic [31:0] bi, output logic [31:0] nq,
                                       output logic ntc);
        longint unsigned modulus;
        modulus = 64'd1 << w;
        nq  = cq;
        ntc = 1'b0;
        case (md)
            2'd0: nq = ai & mask_of(w);
            2'd1: for (int i = 0; i < int'(w); i++) nq[i] = ai[i] ? ~cq[i] : cq[i];
            2'd2: for (int i = 0; i < int'(w); i++)
                case ({ai[i], bi[i]})
                    2'b00: nq[i] = cq[i];
                    2'b01: nq[i] = 1'b0;
                    2'b10: nq[i] = 1'b1;
                    default: nq[i] = ~cq[i];
                endcase
            default: begin
                nq  = 32'((longint'(cq) + 1) % modulus);
                ntc = (longint'(cq) == modulus - 1);
            end
        endcase
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            m_nq[k]  = m_q[k];
            m_ntc[k] = 1'b0;
            if (en)
                model_step(widths[k], m_q[k], mode, {28'b0, a}, {28'b0, b}, m_nq[k], m_ntc[k]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_q[k]  <= rvals[k];
                m_tc[k] <= 1'b0;
            end else begin
                m_q[k]  <= m_nq[k];
                m_tc[k] <= m_ntc[k];
            end
        end
    end

    // Every-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cyc_q%0d", k), dq[k], m_q[k]);
            check($sformatf("cyc_qbar%0d", k), dqb[k], ~m_q[k] & mask_of(widths[k]));
            check($sformatf("cyc_tc%0d", k), dtc[k], {31'b0, m_tc[k]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; a = 4'h0; b = 4'h0;
        repeat (2) step();
        check("rst_q0", dq[0], 32'h0);
        check("rst_qbar0", dqb[0], 32'hF);
        check("rst_tc0", dtc[0], 32'h0);
        check("rst_q1", dq[1], 32'hA);
        check("rst_qbar1", dqb[1], 32'h5);
        rst_n = 1'b1;

        // Count 17 edges: 1..15, 0, 1 with tc only after the 15->0 edge; 1-bit toggles.
        en = 1'b1; mode = 2'b11;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("cnt_q", dq[0], 32'(k % 16));
            check("cnt_qbar", dqb[0], 32'(~(k % 16) & 15));
            check("cnt_tc", dtc[0], (k == 16) ? 32'h1 : 32'h0);
            check("w1_q", dq[2], 32'(k % 2));
            check("w1_tc", dtc[2], (k % 2 == 0) ? 32'h1 : 32'h0);
        end

        // T mode from 0101.
        mode = 2'b00; a = 4'b0101; step();
        check("t_load", dq[0], 32'h5);
        mode = 2'b01; a = 4'b0011; step();
        check("t_toggle", dq[0], 32'h6);
        a = 4'b0000; step();
        check("t_hold", dq[0], 32'h6);

        // JK from 1010, bit by bit: invert, set, clear, hold -> 0100.
        mode = 2'b00; a = 4'b1010; step();
        mode = 2'b10; a = 4'b1100; b = 4'b1010; step();
        check("jk_q", dq[0], 32'h4);

        // D with enable low for three edges, then high.
        mode = 2'b00; a = 4'b0110; b = 4'h0; step();
        en = 1'b0; a = 4'b1001;
        repeat (3) begin
            step();
            check("en0_hold", dq[0], 32'h6);
            check("en0_tc", dtc[0], 32'h0);
        end
        en = 1'b1; step();
        check("d_q", dq[0], 32'h9);

        // Enable low at all-ones in COUNT: no wrap, no pulse.
        a = 4'hF; step();
        en = 1'b0; mode = 2'b11; step();
        check("cnt_en0_q", dq[0], 32'hF);
        check("cnt_en0_tc", dtc[0], 32'h0);

        // Wrap, then reset pulse during the tc-high cycle.
        en = 1'b1; step();
        check("wrap_q", dq[0], 32'h0);
        check("wrap_tc", dtc[0], 32'h1);
        check("wrap_tc1", dtc[1], 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_q0", dq[0], 32'h0);
        check("arst_tc0", dtc[0], 32'h0);
        check("arst_q1", dq[1], 32'hA);
        check("arst_qbar1", dqb[1], 32'h5);
        check("arst_tc1", dtc[1], 32'h0);
        rst_n = 1'b1;
        step();
        check("resume_q0_1", dq[0], 32'h1);
        check("resume_q1_1", dq[1], 32'hB);
        step();
        check("resume_q0_2", dq[0], 32'h2);
        check("resume_q1_2", dq[1], 32'hC);

        // Leave COUNT on the would-be wrap edge.
        mode = 2'b00; a = 4'hE; step();
        mode = 2'b11; step();
        check("pre_wrap_q", dq[0], 32'hF);
        check("pre_wrap_tc", dtc[0], 32'h0);
        mode = 2'b00; a = 4'h0; step();
        check("nowrap_q", dq[0], 32'h0);
        check("nowrap_tc", dtc[0], 32'h0);

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
